readout_capture: RTL and testbench

- Receiving end of the digital_unison readout interface.
- Samples the 2-bit read_out_I / read_out_Q streams on edges of the unison master clock.
- Deserialises the streams into per-core I/Q words and buffers them in a FIFO.
- Host firmware reads the words through a Wishbone slave in the user project wrapper, in place of slow LA polling.

---
 rtl/readout_capture.sv | 215 +++++++++++++++++++++
 tb/tb_readout_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_capture.sv
// rtl/readout_capture.sv - digital_unison readout receiver: sync, deserialise, FIFO, Wishbone slave
// Optional feature macro: READOUT_CAPTURE_IRQ_EN (CTRL.irq_en and registered irq_o)
module readout_capture #(
  parameter int          WORD_BITS  = 16,
  parameter int          NUM_CORES  = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ser_clk_i,
  input  logic        frame_i,
  input  logic [1:0]  read_out_I,
  input  logic [1:0]  read_out_Q,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);
  localparam int PAIRS = WORD_BITS / 2;
  localparam int BCW   = $clog2(PAIRS);
  localparam int CCW   = $clog2(NUM_CORES + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(PAIRS - 1);
  localparam logic [CCW-1:0] CORE_LAST = CCW'(NUM_CORES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FRAME = 2'd1, SHIFT = 2'd2} state_t;

  state_t state, state_n;

  // Two-flop synchronisers, plus one extra ser_clk stage for rising-edge detection
  logic       ser_s1, ser_s2, ser_prev, frm_s1, frm_s2;
  logic [1:0] i_s1, i_s2, q_s1, q_s2;
  logic       strobe;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ser_s1 <= 1'b0; ser_s2 <= 1'b0; ser_prev <= 1'b0;
      frm_s1 <= 1'b0; frm_s2 <= 1'b0;
      i_s1 <= '0; i_s2 <= '0; q_s1 <= '0; q_s2 <= '0;
    end else begin
      ser_s1 <= ser_clk_i;  ser_s2 <= ser_s1;  ser_prev <= ser_s2;
      frm_s1 <= frame_i;    frm_s2 <= frm_s1;
      i_s1 <= read_out_I;   i_s2 <= i_s1;
      q_s1 <= read_out_Q;   q_s2 <= q_s1;
    end
  end

  assign strobe = ser_s2 & ~ser_prev;

  // Wishbone decode; all register side effects happen in the ack cycle
  logic        sel, ack, act, is_ctrl, is_stat, is_data, wr_ctrl, flush, pop;
  logic        en, ovf, full, empty, ctrl_irq_en;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] mem [FIFO_DEPTH];
  logic [31:0] rdata;

  assign sel     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign act     = ack & sel;
  assign is_ctrl = (wbs_adr_i[3:0] == 4'h0);
  assign is_stat = (wbs_adr_i[3:0] == 4'h4);
  assign is_data = (wbs_adr_i[3:0] == 4'h8);
  assign wr_ctrl = act & wbs_we_i & is_ctrl & wbs_sel_i[0];
  assign flush   = wr_ctrl & wbs_dat_i[1];
  assign pop     = act & ~wbs_we_i & is_data & ~empty;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);

  // Single-cycle ack, one cycle after select, never back to back
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ack <= 1'b0;
    else          ack <= sel & ~ack;
  end

  // CTRL register; flush is a pulse and is not stored
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)     en <= 1'b0;
    else if (wr_ctrl) en <= wbs_dat_i[0];
  end

`ifdef READOUT_CAPTURE_IRQ_EN
  logic irq_en, irq_q;

  // Interrupt enable bit and registered interrupt request
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= wbs_dat_i[2];
      irq_q <= irq_en & (~empty | ovf);
    end
  end

  assign ctrl_irq_en = irq_en;
  assign irq_o       = irq_q;
`else
  assign ctrl_irq_en = 1'b0;
  assign irq_o       = 1'b0;
`endif

  // Read data is driven only while ack is high; DATA shows the head before the pop edge
  always_comb begin
    rdata = '0;
    if (ack) begin
      if (is_ctrl)
        rdata = {29'd0, ctrl_irq_en, 1'b0, en};
      else if (is_stat)
        rdata = {18'd0, state, 1'b0, ovf, full, empty, 8'(count)};
      else if (is_data && !empty)
        rdata = mem[rd_ptr];
    end
  end

  assign wbs_ack_o = ack;
  assign wbs_dat_o = rdata;

  // Deserialiser control
  logic [WORD_BITS-1:0] sr_i, sr_q;
  logic [BCW-1:0]       bit_cnt;
  logic [CCW-1:0]       core_cnt;
  logic                 load_first, shift_en, push_word, push_ok;
  logic [31:0]          entry;

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (en) state_n = WAIT_FRAME;
      WAIT_FRAME: if (!en) state_n = IDLE;
                  else if (strobe && frm_s2) state_n = SHIFT;
      SHIFT:      if (!en) state_n = IDLE;
                  else if (strobe && frm_s2) state_n = SHIFT;
                  else if (strobe && bit_cnt == BIT_LAST && core_cnt == CORE_LAST)
                    state_n = WAIT_FRAME;
      default:    state_n = IDLE;
    endcase
  end

  // FSM outputs: a frame marker always restarts a frame, otherwise SHIFT accumulates pairs
  always_comb begin
    load_first = 1'b0;
    shift_en   = 1'b0;
    push_word  = 1'b0;
    if (en && strobe && state != IDLE) begin
      if (frm_s2) begin
        load_first = 1'b1;
      end else if (state == SHIFT) begin
        shift_en  = 1'b1;
        push_word = (bit_cnt == BIT_LAST);
      end
    end
  end

  // Shift registers and bit/core counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sr_i <= '0; sr_q <= '0; bit_cnt <= '0; core_cnt <= '0;
    end else if (!en) begin
      bit_cnt  <= '0;
      core_cnt <= '0;
    end else if (load_first || shift_en) begin
      sr_i <= {sr_i[WORD_BITS-3:0], i_s2};
      sr_q <= {sr_q[WORD_BITS-3:0], q_s2};
      if (load_first) begin
        bit_cnt  <= BCW'(1);
        core_cnt <= '0;
      end else if (bit_cnt == BIT_LAST) begin
        bit_cnt  <= '0;
        core_cnt <= core_cnt + CCW'(1);
      end else begin
        bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

  // The completing pair is appended combinationally so the word lands in the FIFO on the strobe edge
  assign entry   = 32'({sr_q[WORD_BITS-3:0], q_s2, sr_i[WORD_BITS-3:0], i_s2});
  assign push_ok = push_word & ~flush & (~full | pop);

  // FIFO storage
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  // FIFO pointers, occupancy and sticky overflow; flush beats a concurrent push
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0; ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (push_word && full && !pop) ovf <= 1'b1;
    end
  end

  logic unused;
  assign unused = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:2],
                    sr_i[WORD_BITS-1 -: 2], sr_q[WORD_BITS-1 -: 2]};
endmodule

// File: tb/tb_readout_capture.sv
// tb/tb_readout_capture.sv - randomized self-checking bench for readout_capture
module tb_readout_capture;
  localparam int W = 16, NC = 8, DEPTH = 8, PAIRS = W / 2;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE, A_STAT = BASE + 32'h4, A_DATA = BASE + 32'h8;

  logic clk = 1'b0, rst = 1'b1, ser_clk = 1'b0, frame = 1'b0;
  logic [1:0] r_i = '0, r_q = '0;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0, dat_o;
  logic ack, irq;

  readout_capture dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ser_clk_i(ser_clk), .frame_i(frame),
    .read_out_I(r_i), .read_out_Q(r_q),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model: FIFO contents as a queue, plus sticky overflow and frame progress
  logic [31:0] model_q[$];
  bit model_ovf = 0, en_m = 0, mid_frame = 0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
    int k = 0;
    rd = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
    do begin tick(1); k++; end while (!ack && k < 8);
    n_vec++;
    if (!ack || k != 1) begin
      n_err++;
      $display("FAIL wb_ack_latency adr=%h: ack=%b after %0d cycles, required ack=1 after 1", a, ack, k);
    end
    rd = dat_o;
    tick(1);
    n_vec++;
    if (ack !== 1'b0) begin
      n_err++;
      $display("FAIL wb_ack_pulse adr=%h: ack=%b on second cycle, required 0", a, ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick(1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] junk;
    wb_access(1'b1, a, d, junk);
  endtask

  task automatic send_pair(input logic f, input logic [1:0] pi, input logic [1:0] pq);
    frame = f; r_i = pi; r_q = pq; ser_clk = 1'b0;
    tick(3);
    ser_clk = 1'b1;
    tick(3);
    ser_clk = 1'b0;
  endtask

  task automatic send_word(input logic f, input logic [W-1:0] iw, input logic [W-1:0] qw);
    for (int p = 0; p < PAIRS; p++)
      send_pair(f && p == 0, iw[W-1-2*p -: 2], qw[W-1-2*p -: 2]);
  endtask

  task automatic model_push(input logic [W-1:0] iw, input logic [W-1:0] qw);
    if (model_q.size() < DEPTH) model_q.push_back({qw, iw});
    else model_ovf = 1;
  endtask

  task automatic send_frame(input int nwords);
    logic [W-1:0] iw, qw;
    for (int c = 0; c < nwords; c++) begin
      iw = W'($urandom); qw = W'($urandom);
      send_word(c == 0, iw, qw);
      model_push(iw, qw);
    end
    mid_frame = (nwords < NC);
  endtask

  task automatic send_partial(input int npairs);
    for (int p = 0; p < npairs; p++)
      send_pair(p == 0, 2'($urandom), 2'($urandom));
    mid_frame = 1;
  endtask

  task automatic check_status(input string nm);
    logic [31:0] got, exp;
    int cnt = model_q.size();
    int st = !en_m ? 0 : (mid_frame ? 2 : 1);
    exp = (st << 12) | (int'(model_ovf) << 10) | (int'(cnt == DEPTH) << 9) |
          (int'(cnt == 0) << 8) | cnt;
    wb_access(1'b0, A_STAT, 32'h0, got);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL status_%s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic check_pop(input string nm);
    logic [31:0] got, exp;
    exp = (model_q.size() > 0) ? model_q.pop_front() : 32'h0;
    wb_access(1'b0, A_DATA, 32'h0, got);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL data_%s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic check_irq(input string nm, input logic exp);
    n_vec++;
    if (irq !== exp) begin
      n_err++;
      $display("FAIL irq_%s: got %b, expected %b", nm, irq, exp);
    end
  endtask

  task automatic flush_fifo(input logic [31:0] extra);
    wb_write(A_CTRL, 32'h3 | extra);
    en_m = 1; model_q.delete(); model_ovf = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3); rst = 1'b0; tick(1);
    n_vec++;
    if (ack !== 1'b0 || dat_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: ack=%b dat=%h, expected 0 and 0", ack, dat_o);
    end
    check_irq("reset", 1'b0);
    check_status("reset");
    check_pop("reset_empty");
  endtask

  task automatic test_single_word();
    wb_write(A_CTRL, 32'h1); en_m = 1;
    tick(2);
    send_word(1'b1, 16'hAAAA, 16'h5555);
    model_push(16'hAAAA, 16'h5555); mid_frame = 1;
    check_status("one_word");
    n_vec++;
    if (model_q[0] !== 32'h5555_AAAA) begin
      n_err++;
      $display("FAIL model_pattern: got %h, expected 5555aaaa", model_q[0]);
    end
    check_pop("one_word");
    check_status("one_word_drained");
  endtask

  task automatic test_overflow();
    flush_fifo(32'h0);
    for (int f = 0; f < 9; f++) send_frame(NC);
    check_status("overflow");
    for (int k = 0; k < 9; k++) check_pop("overflow_readback");
    check_status("overflow_drained");
  endtask

  task automatic test_frame_restart();
    flush_fifo(32'h0);
    send_partial(3);
    send_frame(1);
    check_status("restart");
    check_pop("restart");
  endtask

  task automatic test_disable_mid_word();
    flush_fifo(32'h0);
    send_partial(3);
    wb_write(A_CTRL, 32'h0); en_m = 0; mid_frame = 0;
    check_status("disabled");
    send_pair(1'b1, 2'b11, 2'b11);
    check_status("idle_ignores_strobe");
    wb_write(A_CTRL, 32'h1); en_m = 1;
    tick(2);
    send_frame(NC);
    check_status("reenabled");
    for (int k = 0; k < NC; k++) check_pop("reenabled");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) send_partial($urandom_range(1, PAIRS - 1));
      send_frame($urandom_range(1, NC));
      repeat ($urandom_range(0, 4)) check_pop("random");
      check_status("random");
    end
    while (model_q.size() > 0) check_pop("random_drain");
  endtask

  task automatic test_irq();
    logic [31:0] got, exp;
    logic [W-1:0] iw, qw;
`ifdef READOUT_CAPTURE_IRQ_EN
    exp = 32'h5;
`else
    exp = 32'h1;
`endif
    flush_fifo(32'h4);
    wb_access(1'b0, A_CTRL, 32'h0, got);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ctrl_readback: got %h, expected %h", got, exp);
    end
    check_irq("empty", 1'b0);
    iw = W'($urandom); qw = W'($urandom);
    for (int p = 0; p < PAIRS - 1; p++)
      send_pair(p == 0, iw[W-1-2*p -: 2], qw[W-1-2*p -: 2]);
    frame = 1'b0; r_i = iw[1:0]; r_q = qw[1:0];
    tick(3);
    ser_clk = 1'b1;
    tick(3);
    check_irq("before_push", 1'b0);
    tick(1);
`ifdef READOUT_CAPTURE_IRQ_EN
    check_irq("after_push", 1'b1);
`else
    check_irq("tied_off", 1'b0);
`endif
    ser_clk = 1'b0;
    model_push(iw, qw); mid_frame = 1;
    check_pop("irq_word");
    check_irq("after_pop", 1'b0);
    send_frame(NC);
    send_frame(1);
    tick(2);
`ifdef READOUT_CAPTURE_IRQ_EN
    check_irq("full", 1'b1);
`else
    check_irq("full_tied_off", 1'b0);
`endif
    for (int k = 0; k < DEPTH; k++) check_pop("irq_drain");
    tick(2);
`ifdef READOUT_CAPTURE_IRQ_EN
    check_irq("ovf_only", 1'b1);
`else
    check_irq("ovf_tied_off", 1'b0);
`endif
    check_status("ovf_sticky");
    flush_fifo(32'h4);
    tick(2);
    check_irq("after_flush", 1'b0);
    check_status("after_flush");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_frame_restart();
    test_disable_mid_word();
    test_random();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
